// File: rtl/register_file.sv
// General-register file: 31 storage registers (R1..R31) plus a hardwired-zero R0,
// one write port selected by a one-hot enable vector and two combinational read
// ports with write-through bypass. A multi-bit enable is rejected and latched in a
// sticky error flag.
module register_file #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      WE,
  input  logic [WIDTH-1:0] PW,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  output logic [WIDTH-1:0] PA,
  output logic [WIDTH-1:0] PB,
  output logic             WE_ERR
);

  logic [WIDTH-1:0] regs_q [1:31];
  logic             err_q;
  logic             multi_hot;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hot = |(WE & (WE - 32'd1));

  // Register array update; a multi-bit enable writes nothing, and bit 0 has no storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k < 32; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (WE[k] && !multi_hot) begin
          regs_q[k] <= PW;
        end
      end
    end
  end

  // Sticky error flag, raised on the edge that samples an illegal enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (multi_hot) begin
      err_q <= 1'b1;
    end
  end

  assign WE_ERR = err_q;

  // Combinational read ports with same-cycle bypass of a legal write.
  always_comb begin
    PA = '0;
    PB = '0;
    for (int k = 1; k < 32; k++) begin
      if (RA == 5'(k)) PA = regs_q[k];
      if (RB == 5'(k)) PB = regs_q[k];
    end
    // WE[addr] set with no other bit set means a valid one-hot write to addr.
    if (!multi_hot && WE[RA] && (RA != 5'd0)) PA = PW;
    if (!multi_hot && WE[RB] && (RB != 5'd0)) PB = PW;
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by randomized traffic
// checked against an array-based model of the register file.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [31:0] WE;
  logic [31:0] PW;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [31:0] PA;
  logic [31:0] PB;
  logic        WE_ERR;

  int checks;
  int passed;

  logic [31:0] m_regs [32];
  logic        m_err;

  register_file #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .WE     (WE),
    .PW     (PW),
    .RA     (RA),
    .RB     (RB),
    .PA     (PA),
    .PB     (PB),
    .WE_ERR (WE_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
    m_err = 1'b0;
  endtask

  // Expected read: R0 is zero, a single-bit enable on a nonzero address bypasses.
  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
    if ($countones(WE) == 1 && WE[addr]) return PW;
    return m_regs[addr];
  endfunction

  // Apply the write rule to the model, then take one clock edge.
  task automatic tick();
    if (!reset) begin
      if ($countones(WE) > 1) begin
        m_err = 1'b1;
      end else begin
        for (int k = 1; k < 32; k++) begin
          if (WE[k]) m_regs[k] = PW;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] data);
    WE = 32'd1 << idx;
    PW = data;
    tick();
    WE = '0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check("reset_err_clear", {31'd0, WE_ERR}, 32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    WE = '0; PW = '0; RA = '0; RB = '0;
    model_clear();
    #12;
    reset = 1'b0;
    #1;

    // Reset state: every address reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      RA = 5'(a);
      RB = 5'(31 - a);
      #1;
      check("reset_pa", PA, 32'd0);
      check("reset_pb", PB, 32'd0);
    end
    check("reset_err", {31'd0, WE_ERR}, 32'd0);

    // Write and read-back.
    WE = 32'h0000_0020; PW = 32'hDEAD_BEEF;
    tick();
    WE = '0; RA = 5'd5; RB = 5'd4;
    #1;
    check("wr_pa_r5", PA, 32'hDEAD_BEEF);
    check("wr_pb_r4", PB, 32'd0);

    // R0 protection.
    WE = 32'h1; PW = 32'hFFFF_FFFF;
    tick();
    WE = '0; RA = 5'd0;
    #1;
    check("r0_pa", PA, 32'd0);
    check("r0_err", {31'd0, WE_ERR}, 32'd0);

    // Bypass: old value 1111_1111, new value visible before the edge.
    write_reg(7, 32'h1111_1111);
    WE = 32'h80; PW = 32'h2222_2222; RA = 5'd7; RB = 5'd7;
    #1;
    check("byp_pa_pre", PA, 32'h2222_2222);
    check("byp_pb_pre", PB, 32'h2222_2222);
    tick();
    WE = '0;
    #1;
    check("byp_pa_post", PA, 32'h2222_2222);
    check("byp_pb_post", PB, 32'h2222_2222);

    // Illegal enable: no write, no bypass, sticky error.
    write_reg(3, 32'hA);
    write_reg(9, 32'hB);
    WE = 32'h0000_0208; PW = 32'hC; RA = 5'd3; RB = 5'd9;
    #1;
    check("ill_pa_nobyp", PA, 32'hA);
    check("ill_pb_nobyp", PB, 32'hB);
    tick();
    WE = '0;
    #1;
    check("ill_r3", PA, 32'hA);
    check("ill_r9", PB, 32'hB);
    check("ill_err_set", {31'd0, WE_ERR}, 32'd1);
    write_reg(2, 32'h1234);
    check("ill_err_sticky", {31'd0, WE_ERR}, 32'd1);
    RA = 5'd2;
    #1;
    check("ill_later_write", PA, 32'h1234);
    pulse_reset();

    // Reset mid-stream drops the read immediately, no edge needed.
    write_reg(31, 32'h5A5A_5A5A);
    RA = 5'd31;
    #1;
    check("mid_pre", PA, 32'h5A5A_5A5A);
    reset = 1'b1;
    #1;
    check("mid_async", PA, 32'd0);
    model_clear();
    reset = 1'b0;
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 60)      WE = 32'd1 << $urandom_range(0, 31);
      else if (sel < 72) WE = '0;
      else if (sel < 80) WE = 32'h1;
      else               WE = $urandom | (32'd1 << $urandom_range(0, 31)) | 32'h8000_0000;
      if (sel >= 80 && $countones(WE) < 2) WE = 32'h0000_0006;
      // Keep illegal enables rare enough that the error flag sees both states.
      if (sel >= 80 && $urandom_range(0, 3) != 0) WE = '0;
      PW = $urandom;
      RA = 5'($urandom_range(0, 31));
      RB = ($urandom_range(0, 3) == 0) ? RA : 5'($urandom_range(0, 31));
      #1;
      check("rnd_pa", PA, exp_read(RA));
      check("rnd_pb", PB, exp_read(RB));
      tick();
      check("rnd_err", {31'd0, WE_ERR}, {31'd0, m_err});
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end

    WE = '0;
    for (int a = 0; a < 32; a++) begin
      RA = 5'(a);
      #1;
      check("final_sweep", PA, exp_read(RA));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
